// File: rtl/cdb_arbiter_if.sv
// ============================================================================
// cdb_arbiter_if : result-port and common-data-bus signal bundle.
// Rev 1.0
// ============================================================================
`default_nettype none

package cdb_arbiter_pkg;
    typedef struct packed {
        logic cr0_lt;
        logic cr0_gt;
        logic cr0_eq;
        logic cr0_so;
        logic xer_so;
        logic xer_ov;
        logic xer_ca;
    } cond_exception_t;
endpackage

interface cdb_arbiter_if #(
    parameter int UNITS       = 4,
    parameter int RS_ID_WIDTH = 5
);
    import cdb_arbiter_pkg::*;

    logic [UNITS-1:0]                       unit_valid;
    logic [UNITS-1:0]                       unit_ready;
    logic [UNITS-1:0][0:RS_ID_WIDTH-1]      unit_rs_id;
    logic [UNITS-1:0][0:4]                  unit_reg_addr;
    logic [UNITS-1:0][0:31]                 unit_result;
    cond_exception_t [UNITS-1:0]            unit_cr0_xer;

    logic                                   cdb_valid;
    logic [0:RS_ID_WIDTH-1]                 cdb_rs_id;
    logic [0:31]                            cdb_value;
    logic [0:4]                             cdb_reg_addr;
    cond_exception_t                        cdb_cr0_xer;

    // Execution units plus bus consumers.
    modport master (
        output unit_valid, unit_rs_id, unit_reg_addr, unit_result, unit_cr0_xer,
        input  unit_ready,
        input  cdb_valid, cdb_rs_id, cdb_value, cdb_reg_addr, cdb_cr0_xer
    );

    // The arbiter.
    modport slave (
        input  unit_valid, unit_rs_id, unit_reg_addr, unit_result, unit_cr0_xer,
        output unit_ready,
        output cdb_valid, cdb_rs_id, cdb_value, cdb_reg_addr, cdb_cr0_xer
    );
endinterface

`default_nettype wire

// File: rtl/cdb_arbiter.sv
// ============================================================================
// cdb_arbiter : round-robin collector of execution-unit results onto a
// registered common data bus.
// Rev 1.0
// ============================================================================
`default_nettype none

module cdb_arbiter #(
    parameter int UNITS       = 4,
    parameter int RS_ID_WIDTH = 5
) (
    input  wire logic        clk,
    input  wire logic        rst,
    input  wire logic        flush,
    cdb_arbiter_if.slave     bus
);
    import cdb_arbiter_pkg::*;

    localparam int               PTR_W    = (UNITS > 1) ? $clog2(UNITS) : 1;
    localparam logic [PTR_W-1:0] LAST_RST = PTR_W'(UNITS - 1);

    logic [PTR_W-1:0]       last_grant_q, last_grant_d;
    logic                   cdb_valid_q, cdb_valid_d;
    logic [0:RS_ID_WIDTH-1] cdb_rs_id_q, cdb_rs_id_d;
    logic [0:31]            cdb_value_q, cdb_value_d;
    logic [0:4]             cdb_reg_addr_q, cdb_reg_addr_d;
    cond_exception_t        cdb_cr0_xer_q, cdb_cr0_xer_d;

    logic                   grant_found;
    logic                   grant_en;
    logic [PTR_W-1:0]       grant_idx;
    logic [PTR_W-1:0]       cand;
    logic [UNITS-1:0]       ready;

    // Search begins one past the last winner and wraps, so the last winner
    // is examined last.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = last_grant_q;
        cand        = last_grant_q;
        for (int k = 1; k <= UNITS; k++) begin
            cand = PTR_W'((int'(last_grant_q) + k) % UNITS);
            if (!grant_found && bus.unit_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    assign grant_en = grant_found && rst && !flush;

    always_comb begin
        ready = '0;
        if (grant_en) begin
            ready[grant_idx] = 1'b1;
        end
    end

    assign bus.unit_ready = ready;

    always_comb begin
        last_grant_d   = last_grant_q;
        cdb_valid_d    = 1'b0;
        cdb_rs_id_d    = cdb_rs_id_q;
        cdb_value_d    = cdb_value_q;
        cdb_reg_addr_d = cdb_reg_addr_q;
        cdb_cr0_xer_d  = cdb_cr0_xer_q;
        if (grant_en) begin
            last_grant_d   = grant_idx;
            cdb_valid_d    = 1'b1;
            cdb_rs_id_d    = bus.unit_rs_id[grant_idx];
            cdb_value_d    = bus.unit_result[grant_idx];
            cdb_reg_addr_d = bus.unit_reg_addr[grant_idx];
            cdb_cr0_xer_d  = bus.unit_cr0_xer[grant_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            last_grant_q   <= LAST_RST;
            cdb_valid_q    <= 1'b0;
            cdb_rs_id_q    <= '0;
            cdb_value_q    <= '0;
            cdb_reg_addr_q <= '0;
            cdb_cr0_xer_q  <= '0;
        end else begin
            last_grant_q   <= last_grant_d;
            cdb_valid_q    <= cdb_valid_d;
            cdb_rs_id_q    <= cdb_rs_id_d;
            cdb_value_q    <= cdb_value_d;
            cdb_reg_addr_q <= cdb_reg_addr_d;
            cdb_cr0_xer_q  <= cdb_cr0_xer_d;
        end
    end

    assign bus.cdb_valid    = cdb_valid_q;
    assign bus.cdb_rs_id    = cdb_rs_id_q;
    assign bus.cdb_value    = cdb_value_q;
    assign bus.cdb_reg_addr = cdb_reg_addr_q;
    assign bus.cdb_cr0_xer  = cdb_cr0_xer_q;

endmodule

`default_nettype wire

// File: tb/tb_cdb_arbiter.sv
// ============================================================================
// tb_cdb_arbiter : directed self-checking bench for cdb_arbiter.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_cdb_arbiter;
    import cdb_arbiter_pkg::*;

    localparam int UNITS       = 4;
    localparam int RS_ID_WIDTH = 5;

    logic clk   = 1'b0;
    logic rst   = 1'b0;
    logic flush = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   seen   = 0;
    int   exp_u;

    cdb_arbiter_if #(.UNITS(UNITS), .RS_ID_WIDTH(RS_ID_WIDTH)) bus ();

    cdb_arbiter #(.UNITS(UNITS), .RS_ID_WIDTH(RS_ID_WIDTH)) u_dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_unit(input int u, input logic [4:0] id, input logic [4:0] ra,
                            input logic [31:0] val, input cond_exception_t cr);
        bus.unit_rs_id[u]    = id;
        bus.unit_reg_addr[u] = ra;
        bus.unit_result[u]   = val;
        bus.unit_cr0_xer[u]  = cr;
    endtask

    initial begin
        bus.unit_valid = '0;
        for (int u = 0; u < UNITS; u++) begin
            set_unit(u, 5'(10 + u), 5'(u + 1), 32'hA000_0000 + 32'(u), '0);
        end

        // Reset held with every unit requesting.
        rst = 1'b0;
        bus.unit_valid = 4'b1111;
        for (int c = 0; c < 3; c++) begin
            step();
            check("rst_ready", 64'(bus.unit_ready), 64'(4'b0000));
            check("rst_valid", 64'(bus.cdb_valid), 64'd0);
        end
        check("rst_rsid",  64'(bus.cdb_rs_id), 64'd0);
        check("rst_value", 64'(bus.cdb_value), 64'd0);
        check("rst_reg",   64'(bus.cdb_reg_addr), 64'd0);
        check("rst_cr",    64'(bus.cdb_cr0_xer), 64'd0);

        rst = 1'b1;
        #1;
        check("rel_ready", 64'(bus.unit_ready), 64'(4'b0001));
        step();
        check("rel_valid", 64'(bus.cdb_valid), 64'd1);
        check("rel_rsid",  64'(bus.cdb_rs_id), 64'd10);
        bus.unit_valid = '0;
        step();
        check("no_repeat", 64'(bus.cdb_valid), 64'd0);

        // Single requester on unit 2.
        set_unit(2, 5'd9, 5'd3, 32'hDEAD_BEEF, 7'b1010011);
        bus.unit_valid = 4'b0100;
        #1;
        check("single_ready", 64'(bus.unit_ready), 64'(4'b0100));
        step();
        bus.unit_valid = '0;
        check("single_valid", 64'(bus.cdb_valid), 64'd1);
        check("single_rsid",  64'(bus.cdb_rs_id), 64'd9);
        check("single_reg",   64'(bus.cdb_reg_addr), 64'd3);
        check("single_value", 64'(bus.cdb_value), 64'hDEAD_BEEF);
        check("single_cr",    64'(bus.cdb_cr0_xer), 64'(7'b1010011));
        step();
        check("single_drop", 64'(bus.cdb_valid), 64'd0);
        set_unit(2, 5'd12, 5'd3, 32'hA000_0002, '0);

        // Park pointer on unit 3 so the rotation starts at unit 0.
        bus.unit_valid = 4'b1000;
        step();
        bus.unit_valid = '0;
        check("park3_rsid", 64'(bus.cdb_rs_id), 64'd13);
        step();

        bus.unit_valid = 4'b1111;
        #1;
        for (int c = 0; c < 8; c++) begin
            exp_u = c % 4;
            check("rr_ready", 64'(bus.unit_ready), 64'(4'b0001 << exp_u));
            step();
            check("rr_valid", 64'(bus.cdb_valid), 64'd1);
            check("rr_rsid",  64'(bus.cdb_rs_id), 64'(10 + exp_u));
        end
        bus.unit_valid = '0;
        step();
        check("rr_drop", 64'(bus.cdb_valid), 64'd0);

        // Park pointer on unit 1, then only units 0 and 3 request.
        bus.unit_valid = 4'b0010;
        step();
        bus.unit_valid = 4'b1001;
        #1;
        for (int c = 0; c < 3; c++) begin
            exp_u = (c % 2 == 0) ? 3 : 0;
            check("wrap_ready", 64'(bus.unit_ready), 64'(4'b0001 << exp_u));
            step();
            check("wrap_rsid", 64'(bus.cdb_rs_id), 64'(10 + exp_u));
        end
        bus.unit_valid = '0;
        step();

        // Flush blocks the handshake; the request stays pending.
        bus.unit_valid = 4'b0010;
        flush = 1'b1;
        #1;
        check("flush_ready", 64'(bus.unit_ready), 64'(4'b0000));
        step();
        check("flush_valid", 64'(bus.cdb_valid), 64'd0);
        flush = 1'b0;
        #1;
        check("post_flush_ready", 64'(bus.unit_ready), 64'(4'b0010));
        step();
        check("post_flush_valid", 64'(bus.cdb_valid), 64'd1);
        check("post_flush_rsid",  64'(bus.cdb_rs_id), 64'd11);
        bus.unit_valid = '0;
        step();

        // Unit 1 waits behind unit 0; its result must appear exactly once.
        set_unit(1, 5'd11, 5'd2, 32'h1234_5678, '0);
        bus.unit_valid = 4'b0011;
        #1;
        check("bp_ready0", 64'(bus.unit_ready), 64'(4'b0001));
        step();
        if (bus.cdb_valid && bus.cdb_value == 32'h1234_5678) seen++;
        check("bp_value0", 64'(bus.cdb_value), 64'hA000_0000);
        #1;
        check("bp_ready1", 64'(bus.unit_ready), 64'(4'b0010));
        step();
        if (bus.cdb_valid && bus.cdb_value == 32'h1234_5678) seen++;
        bus.unit_valid = 4'b0001;
        check("bp_value1", 64'(bus.cdb_value), 64'h1234_5678);
        #1;
        check("bp_ready2", 64'(bus.unit_ready), 64'(4'b0001));
        step();
        if (bus.cdb_valid && bus.cdb_value == 32'h1234_5678) seen++;
        bus.unit_valid = '0;
        check("bp_value2", 64'(bus.cdb_value), 64'hA000_0000);
        step();
        if (bus.cdb_valid && bus.cdb_value == 32'h1234_5678) seen++;
        check("bp_drop", 64'(bus.cdb_valid), 64'd0);
        check("bp_once", 64'(seen), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
